// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate byte cache serving one MIU request at a time.
// Read misses refill the whole line from backing memory; all stores are written through.
module cache_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int LINES      = 16,
  parameter int LINE_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cache_req_valid,
  output logic              cache_req_ready,
  input  logic              cache_req_we,
  input  logic [ADDR_W-1:0] cache_req_addr,
  input  logic [7:0]        cache_req_write,
  output logic              cache_resp_valid,
  output logic [7:0]        cache_resp_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata
);
  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_BYTES - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITE_MEM, REFILL, RESP} state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [7:0]          resp_data_q, resp_data_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [OFF_W-1:0]    beat_q, beat_d;
  logic [7:0]          rbyte_q, rbyte_d;

  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [7:0]          data_q [LINES][LINE_BYTES];

  logic [OFF_W-1:0]    off;
  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic                hit;
  logic                line_wr, inval, fill_done;
  logic [OFF_W-1:0]    line_wbyte;
  logic [7:0]          line_wval;
  logic [OFF_W-1:0]    beat_nx;

  assign off     = addr_q[OFF_W-1:0];
  assign idx     = addr_q[OFF_W+IDX_W-1:OFF_W];
  assign tag     = addr_q[ADDR_W-1:OFF_W+IDX_W];
  assign hit     = valid_q[idx] && (tag_q[idx] == tag);
  assign beat_nx = beat_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    beat_d       = beat_q;
    rbyte_d      = rbyte_q;
    line_wr      = 1'b0;
    line_wbyte   = off;
    line_wval    = wdata_q;
    inval        = 1'b0;
    fill_done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (cache_req_valid && ready_q) begin
          we_d    = cache_req_we;
          addr_d  = cache_req_addr;
          wdata_d = cache_req_write;
          ready_d = 1'b0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (we_q) begin
          line_wr     = hit;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = wdata_q;
          state_d     = WRITE_MEM;
        end else if (hit) begin
          resp_data_d  = data_q[idx][off];
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          // Line is invalid for the whole refill so an aborted fill leaves nothing stale.
          inval      = 1'b1;
          beat_d     = '0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {tag, idx, {OFF_W{1'b0}}};
          state_d    = REFILL;
        end
      end
      WRITE_MEM: begin
        if (mem_ack && mem_req_q) begin
          mem_req_d    = 1'b0;
          resp_data_d  = 8'h00;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      REFILL: begin
        if (mem_ack && mem_req_q) begin
          line_wr    = 1'b1;
          line_wbyte = beat_q;
          line_wval  = mem_rdata;
          if (beat_q == off) rbyte_d = mem_rdata;
          if (beat_q == LAST_BEAT) begin
            fill_done    = 1'b1;
            mem_req_d    = 1'b0;
            resp_data_d  = (beat_q == off) ? mem_rdata : rbyte_q;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else begin
            beat_d     = beat_nx;
            mem_addr_d = {tag, idx, beat_nx};
          end
        end
      end
      RESP: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        ready_d   = 1'b0;
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 8'h00;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 8'h00;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 8'h00;
      beat_q       <= '0;
      rbyte_q      <= 8'h00;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      beat_q       <= beat_d;
      rbyte_q      <= rbyte_d;
      if (inval) valid_q[idx] <= 1'b0;
      if (fill_done) begin
        valid_q[idx] <= 1'b1;
        tag_q[idx]   <= tag;
      end
      if (line_wr) data_q[idx][line_wbyte] <= line_wval;
    end
  end

  assign cache_req_ready  = ready_q;
  assign cache_resp_valid = resp_valid_q;
  assign cache_resp_data  = resp_data_q;
  assign mem_req          = mem_req_q;
  assign mem_we           = mem_we_q;
  assign mem_addr         = mem_addr_q;
  assign mem_wdata        = mem_wdata_q;
endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: backing memory returns addr[7:0]^addr[15:8] with programmable ack delay.
module tb_cache_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cache_req_valid = 1'b0;
  logic        cache_req_ready;
  logic        cache_req_we = 1'b0;
  logic [15:0] cache_req_addr = '0;
  logic [7:0]  cache_req_write = '0;
  logic        cache_resp_valid;
  logic [7:0]  cache_resp_data;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  cache_ctrl dut (
    .clk(clk), .reset(reset),
    .cache_req_valid(cache_req_valid), .cache_req_ready(cache_req_ready),
    .cache_req_we(cache_req_we), .cache_req_addr(cache_req_addr), .cache_req_write(cache_req_write),
    .cache_resp_valid(cache_resp_valid), .cache_resp_data(cache_resp_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {logic we; logic [15:0] a; logic [7:0] d; int c;} mem_t;
  mem_t log_q[$];
  int   acc_q[$];
  int   cyc = 0, resp_cnt = 0, resp_cyc = 0, overlap = 0;
  logic [7:0] resp_last = 8'h00;
  int   ack_delay = 0, wait_cnt = 0;
  int   pass_cnt = 0, total_cnt = 0;
  int   last_acc = 0;

  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
  assign mem_rdata = mem_addr[7:0] ^ mem_addr[15:8];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset || !mem_req || mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (!reset && mem_req && mem_ack) log_q.push_back('{mem_we, mem_addr, mem_wdata, cyc + 1});
    if (!reset && cache_req_valid && cache_req_ready) acc_q.push_back(cyc + 1);
  end

  always @(negedge clk) begin
    if (cache_resp_valid) begin
      resp_cnt  = resp_cnt + 1;
      resp_last = cache_resp_data;
      resp_cyc  = cyc;
      if (cache_req_ready) overlap = overlap + 1;
    end
  end

  task automatic send(input logic we, input logic [15:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    cache_req_valid = 1'b1; cache_req_we = we; cache_req_addr = a; cache_req_write = d;
    while (!cache_req_ready && n < 50) begin @(negedge clk); n++; end
    total_cnt++;
    if (n >= 50) $display("FAIL send_timeout addr=%h ready never rose", a);
    else pass_cnt++;
    @(posedge clk); #1;
    last_acc = cyc;
    cache_req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int start = resp_cnt;
    int n = 0;
    while (resp_cnt == start && n < 200) begin @(negedge clk); #1; n++; end
    total_cnt++;
    if (resp_cnt == start) $display("FAIL resp_timeout no response seen");
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({cache_req_ready, cache_resp_valid, mem_req} !== 3'b000)
      $display("FAIL reset_outputs got=%b want=000", {cache_req_ready, cache_resp_valid, mem_req});
    else pass_cnt++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (cache_req_ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", cache_req_ready);
    else pass_cnt++;
  endtask

  task automatic test_refill();
    int r0 = resp_cnt;
    log_q.delete();
    send(1'b0, 16'h0010, 8'h00);
    wait_resp();
    total_cnt++;
    if (resp_last !== 8'h10) $display("FAIL refill_data got=%h want=10", resp_last);
    else pass_cnt++;
    total_cnt++;
    if (log_q.size() != 4) $display("FAIL refill_beats got=%0d want=4", log_q.size());
    else pass_cnt++;
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      total_cnt++;
      if (log_q[i].we !== 1'b0 || log_q[i].a !== 16'h0010 + 16'(i))
        $display("FAIL refill_addr%0d got=%b/%h want=0/%h", i, log_q[i].we, log_q[i].a, 16'h0010 + 16'(i));
      else pass_cnt++;
    end
    if (log_q.size() == 4) begin
      total_cnt++;
      if (resp_cyc != log_q[3].c) $display("FAIL refill_latency got=%0d want=%0d", resp_cyc, log_q[3].c);
      else pass_cnt++;
    end
    repeat (2) @(negedge clk);
    total_cnt++;
    if (resp_cnt - r0 != 1) $display("FAIL refill_pulses got=%0d want=1", resp_cnt - r0);
    else pass_cnt++;
  endtask

  task automatic test_hit();
    log_q.delete();
    send(1'b0, 16'h0012, 8'h00);
    wait_resp();
    total_cnt++;
    if (resp_last !== 8'h12) $display("FAIL hit_data got=%h want=12", resp_last);
    else pass_cnt++;
    total_cnt++;
    if (log_q.size() != 0) $display("FAIL hit_nomem got=%0d want=0", log_q.size());
    else pass_cnt++;
    total_cnt++;
    if (resp_cyc - last_acc != 1) $display("FAIL hit_latency got=%0d want=1", resp_cyc - last_acc);
    else pass_cnt++;
  endtask

  task automatic test_store_hit();
    int bad = 0;
    int start;
    int n = 0;
    log_q.delete();
    ack_delay = 3;
    send(1'b1, 16'h0011, 8'hAB);
    start = resp_cnt;
    while (resp_cnt == start && n < 100) begin
      @(negedge clk); #1; n++;
      if (mem_req && (mem_we !== 1'b1 || mem_addr !== 16'h0011 || mem_wdata !== 8'hAB)) bad++;
    end
    total_cnt++;
    if (resp_cnt == start) $display("FAIL store_timeout no response");
    else pass_cnt++;
    total_cnt++;
    if (bad != 0) $display("FAIL store_stable got=%0d unstable cycles want=0", bad);
    else pass_cnt++;
    total_cnt++;
    if (log_q.size() != 1 || log_q[0].we !== 1'b1 || log_q[0].a !== 16'h0011 || log_q[0].d !== 8'hAB)
      $display("FAIL store_write got=%0d entries want=1 write 0011/AB", log_q.size());
    else pass_cnt++;
    if (log_q.size() == 1) begin
      total_cnt++;
      if (resp_cyc != log_q[0].c) $display("FAIL store_latency got=%0d want=%0d", resp_cyc, log_q[0].c);
      else pass_cnt++;
    end
    total_cnt++;
    if (resp_last !== 8'h00) $display("FAIL store_respdata got=%h want=00", resp_last);
    else pass_cnt++;
    ack_delay = 0;
    log_q.delete();
    send(1'b0, 16'h0011, 8'h00);
    wait_resp();
    total_cnt++;
    if (resp_last !== 8'hAB || log_q.size() != 0)
      $display("FAIL store_readback got=%h/%0d want=AB/0", resp_last, log_q.size());
    else pass_cnt++;
  endtask

  task automatic test_store_miss();
    log_q.delete();
    send(1'b1, 16'h0400, 8'h5C);
    wait_resp();
    total_cnt++;
    if (log_q.size() != 1 || log_q[0].we !== 1'b1 || log_q[0].a !== 16'h0400 || log_q[0].d !== 8'h5C)
      $display("FAIL smiss_write got=%0d entries want=1 write 0400/5C", log_q.size());
    else pass_cnt++;
    log_q.delete();
    send(1'b0, 16'h0010, 8'h00);
    wait_resp();
    total_cnt++;
    if (resp_last !== 8'h10 || log_q.size() != 0)
      $display("FAIL smiss_keep got=%h/%0d want=10/0", resp_last, log_q.size());
    else pass_cnt++;
    log_q.delete();
    send(1'b0, 16'h0400, 8'h00);
    wait_resp();
    total_cnt++;
    if (resp_last !== 8'h04 || log_q.size() != 4)
      $display("FAIL smiss_noalloc got=%h/%0d want=04/4", resp_last, log_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int r0;
    int n = 0;
    log_q.delete();
    send(1'b0, 16'h0410, 8'h00);
    r0 = resp_cnt;
    while (log_q.size() < 2 && n < 50) begin @(negedge clk); n++; end
    total_cnt++;
    if (log_q.size() < 2) $display("FAIL abort_beats got=%0d want>=2", log_q.size());
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (mem_req !== 1'b0 || cache_req_ready !== 1'b0)
      $display("FAIL abort_memreq got=%b/%b want=0/0", mem_req, cache_req_ready);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    total_cnt++;
    if (resp_cnt != r0) $display("FAIL abort_noresp got=%0d want=%0d", resp_cnt, r0);
    else pass_cnt++;
    log_q.delete();
    send(1'b0, 16'h0010, 8'h00);
    wait_resp();
    total_cnt++;
    if (resp_last !== 8'h10 || log_q.size() != 4)
      $display("FAIL abort_remiss got=%h/%0d want=10/4", resp_last, log_q.size());
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    acc_q.delete();
    overlap = 0;
    @(negedge clk);
    cache_req_valid = 1'b1; cache_req_we = 1'b0; cache_req_addr = 16'h0010;
    while (acc_q.size() < 2 && n < 50) begin @(negedge clk); n++; end
    cache_req_valid = 1'b0;
    wait_resp();
    repeat (2) @(negedge clk);
    total_cnt++;
    if (acc_q.size() != 2) $display("FAIL b2b_accepts got=%0d want=2", acc_q.size());
    else pass_cnt++;
    if (acc_q.size() == 2) begin
      total_cnt++;
      if (acc_q[1] - acc_q[0] != 3) $display("FAIL b2b_spacing got=%0d want=3", acc_q[1] - acc_q[0]);
      else pass_cnt++;
    end
    total_cnt++;
    if (overlap != 0) $display("FAIL b2b_overlap got=%0d want=0", overlap);
    else pass_cnt++;
    total_cnt++;
    if (resp_last !== 8'h10) $display("FAIL b2b_data got=%h want=10", resp_last);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_refill();
    test_hit();
    test_store_hit();
    test_store_miss();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
